cv32e40s_irq_gen: RTL and testbench

Memory-mapped machine interrupt source that drives the core's `irq_i` vector. It generates:
- MSI (bit 3) from a software-writable MSIP register.
- MTI (bit 7) from a 64-bit mtime/mtimecmp timer with a programmable prescaler.
- Optionally, latched edge-triggered custom interrupts on bits 31:16.

It sits outside the core on the peripheral bus and is the producing end of the level-triggered interrupt lines that the core registers, masks with MIE and prioritises.

---
 rtl/cv32e40s_irq_gen.sv | 138 +++++++++++++
 tb/tb_cv32e40s_irq_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_irq_gen.sv
// cv32e40s_irq_gen: memory-mapped MSI/MTI interrupt source; define CV32E40S_IRQ_GEN_FIRQ_EN for edge-triggered custom irqs on bits 31:16
module cv32e40s_irq_gen #(
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter logic [15:0] PRESCALE_RST = 16'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic [15:0] fast_irq_i,
   output logic [31:0] irq_o
);
   logic [2:0]  idx;
   logic        bad_addr;
   logic        wr;
   logic        tick;
   logic [31:0] rdata_c;
   logic        msip_q;
   logic [63:0] mtimecmp_q;
   logic [63:0] mtime_q;
   logic [63:0] mtime_d;
   logic [15:0] prescale_q;
   logic [15:0] pcnt_q;
   logic [15:0] pcnt_d;
   logic        mti_q;
   logic        rvalid_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [15:0] firq_pend;

   assign idx   = addr_i[4:2];
   assign gnt_o = req_i;
`ifdef CV32E40S_IRQ_GEN_FIRQ_EN
   assign bad_addr = idx == 3'd7;
`else
   assign bad_addr = idx >= 3'd6;
`endif
   assign wr = req_i & we_i & ~bad_addr;

   // read mux over the register map, sampled at grant time
   always_comb begin
      rdata_c = '0;
      case (idx)
         3'd0:    rdata_c = {31'd0, msip_q};
         3'd1:    rdata_c = mtimecmp_q[31:0];
         3'd2:    rdata_c = mtimecmp_q[63:32];
         3'd3:    rdata_c = mtime_q[31:0];
         3'd4:    rdata_c = mtime_q[63:32];
         3'd5:    rdata_c = {16'd0, prescale_q};
         3'd6:    rdata_c = {16'd0, firq_pend};
         default: rdata_c = '0;
      endcase
   end

   // a written half of mtime overrides the tick; the other half keeps its old value with no carry
   assign tick    = pcnt_q == prescale_q;
   assign mtime_d = (wr && idx == 3'd3) ? {mtime_q[63:32], wdata_i} :
                    (wr && idx == 3'd4) ? {wdata_i, mtime_q[31:0]} :
                    tick ? mtime_q + 64'd1 : mtime_q;
   assign pcnt_d  = ((wr && idx == 3'd5) || tick) ? 16'd0 : pcnt_q + 16'd1;

   // software registers, timer and registered compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msip_q     <= 1'b0;
         mtimecmp_q <= MTIMECMP_RST;
         mtime_q    <= '0;
         prescale_q <= PRESCALE_RST;
         pcnt_q     <= '0;
         mti_q      <= 1'b0;
      end else begin
         if (wr && idx == 3'd0) msip_q <= wdata_i[0];
         if (wr && idx == 3'd1) mtimecmp_q[31:0] <= wdata_i;
         if (wr && idx == 3'd2) mtimecmp_q[63:32] <= wdata_i;
         if (wr && idx == 3'd5) prescale_q <= wdata_i[15:0];
         mtime_q <= mtime_d;
         pcnt_q  <= pcnt_d;
         mti_q   <= mtime_q >= mtimecmp_q;
      end
   end

   // bus response one cycle after grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= req_i;
         err_q    <= req_i & bad_addr;
         rdata_q  <= (req_i && !we_i && !bad_addr) ? rdata_c : '0;
      end
   end

`ifdef CV32E40S_IRQ_GEN_FIRQ_EN
   logic [15:0] sync1_q;
   logic [15:0] sync2_q;
   logic [15:0] prev_q;
   logic [15:0] firq_set;
   logic [15:0] firq_clr;
   logic [1:0]  unused_addr;

   assign firq_set    = sync2_q & ~prev_q;
   assign firq_clr    = (wr && idx == 3'd6) ? wdata_i[15:0] : '0;
   assign unused_addr = addr_i[1:0];

   // synchronise, detect rising edges and latch them; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         firq_pend <= '0;
      end else begin
         sync1_q   <= fast_irq_i;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         firq_pend <= (firq_pend & ~firq_clr) | firq_set;
      end
   end
`else
   logic [17:0] unused_in;

   assign unused_in = {fast_irq_i, addr_i[1:0]};
   assign firq_pend = '0;
`endif

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;
   assign irq_o    = {firq_pend, 8'd0, mti_q, 3'd0, msip_q, 3'd0};
endmodule

// File: tb/tb_cv32e40s_irq_gen.sv
// tb_cv32e40s_irq_gen: table vectors, directed corner sequences and random traffic against a reference model
module tb_cv32e40s_irq_gen;
`ifdef CV32E40S_IRQ_GEN_FIRQ_EN
   localparam bit FIRQ = 1'b1;
`else
   localparam bit FIRQ = 1'b0;
`endif

   typedef struct {
      bit        we;
      bit [4:0]  addr;
      bit [31:0] wdata;
      bit        exp_err;
      bit        chk_rd;
      bit [31:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [15:0] firq = '0;
   logic        gnt;
   logic        rvalid;
   logic        err;
   logic [31:0] rdata;
   logic [31:0] irq;
   int total = 0;
   int bad = 0;

   bit        m_msip, m_mti, m_rv, m_err;
   bit [63:0] m_time, m_cmp;
   int        m_pre, m_cnt;
   bit [31:0] m_rd;
   bit [15:0] m_pend, p1, p2, p3;

   always #5 clk = ~clk;

   cv32e40s_irq_gen dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
      .fast_irq_i(firq), .irq_o(irq)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic m_reset();
      m_msip = 0; m_mti = 0; m_rv = 0; m_err = 0; m_rd = 0;
      m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_pre = 0; m_cnt = 0;
      m_pend = 0; p1 = 0; p2 = 0; p3 = 0;
   endtask

   // one clock edge of the register map, computed from current model state and bus inputs
   task automatic m_step();
      int i;
      bit ok, tick;
      bit [31:0] rv;
      bit [15:0] clr;
      bit [63:0] t;
      i = int'(addr[4:2]);
      ok = (i <= 5) || (FIRQ && i == 6);
      case (i)
         0: rv = {31'd0, m_msip};
         1: rv = m_cmp[31:0];
         2: rv = m_cmp[63:32];
         3: rv = m_time[31:0];
         4: rv = m_time[63:32];
         5: rv = m_pre;
         6: rv = {16'd0, m_pend};
         default: rv = 0;
      endcase
      m_rv = req;
      m_err = req && !ok;
      m_rd = (req && !we && ok) ? rv : 0;
      m_mti = m_time >= m_cmp;
      tick = m_cnt == m_pre;
      t = tick ? m_time + 64'd1 : m_time;
      m_cnt = tick ? 0 : m_cnt + 1;
      clr = 0;
      if (req && we && ok) begin
         case (i)
            0: m_msip = wdata[0];
            1: m_cmp = {m_cmp[63:32], wdata};
            2: m_cmp = {wdata, m_cmp[31:0]};
            3: t = {m_time[63:32], wdata};
            4: t = {wdata, m_time[31:0]};
            5: begin m_pre = int'(wdata[15:0]); m_cnt = 0; end
            default: clr = wdata[15:0];
         endcase
      end
      m_time = t;
      if (FIRQ) m_pend = (m_pend & ~clr) | (p2 & ~p3);
      p3 = p2; p2 = p1; p1 = firq;
   endtask

   task automatic cyc(bit r, bit w, bit [4:0] a, bit [31:0] d);
      req = r; we = w; addr = a; wdata = d;
      #1;
      chk("gnt", gnt, r);
      m_step();
      @(posedge clk);
      #1;
      chk("irq", irq, {m_pend, 8'd0, m_mti, 3'd0, m_msip, 3'd0});
      chk("rsp", {rvalid, err, rdata}, {m_rv, m_err, m_rd});
   endtask

   initial begin
      vec_t tbl[$];
      int n;
      bit [2:0] ri;
      bit [31:0] rd;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_irq", irq, 0);
      chk("reset_rsp", {rvalid, err, rdata}, 0);
      rst_n = 1'b1;

      tbl.push_back('{0, 5'h00, 0, 0, 1, 0});
      tbl.push_back('{0, 5'h04, 0, 0, 1, 32'hFFFF_FFFF});
      tbl.push_back('{0, 5'h08, 0, 0, 1, 32'hFFFF_FFFF});
      tbl.push_back('{0, 5'h0C, 0, 0, 0, 0});
      tbl.push_back('{0, 5'h10, 0, 0, 1, 0});
      tbl.push_back('{0, 5'h14, 0, 0, 1, 0});
      tbl.push_back('{0, 5'h1C, 0, 1, 1, 0});
      tbl.push_back('{1, 5'h1C, 32'h5A5A, 1, 1, 0});
      tbl.push_back('{0, 5'h17, 0, 0, 1, 0});
      tbl.push_back('{1, 5'h00, 1, 0, 1, 0});
      tbl.push_back('{0, 5'h00, 0, 0, 1, 1});
      tbl.push_back('{1, 5'h00, 0, 0, 1, 0});
      tbl.push_back('{0, 5'h03, 0, 0, 1, 0});
      tbl.push_back('{1, 5'h04, 32'h1234, 0, 1, 0});
      tbl.push_back('{0, 5'h04, 0, 0, 1, 32'h1234});
      tbl.push_back('{0, 5'h08, 0, 0, 1, 32'hFFFF_FFFF});
      tbl.push_back('{0, 5'h18, 0, !FIRQ, 1, 0});
      tbl.push_back('{1, 5'h18, 32'hFFFF, !FIRQ, 1, 0});
      tbl.push_back('{1, 5'h04, 32'hFFFF_FFFF, 0, 1, 0});
      tbl.push_back('{0, 5'h04, 0, 0, 1, 32'hFFFF_FFFF});
      foreach (tbl[k]) begin
         cyc(1, tbl[k].we, tbl[k].addr, tbl[k].wdata);
         chk("tbl_rvalid", rvalid, 1);
         chk("tbl_err", err, tbl[k].exp_err);
         if (tbl[k].chk_rd) chk("tbl_rdata", rdata, tbl[k].exp_rd);
      end

      // timer with prescale 3 reaching mtimecmp = 10
      cyc(1, 1, 5'h14, 3);
      cyc(1, 1, 5'h0C, 0);
      cyc(1, 1, 5'h10, 0);
      cyc(1, 1, 5'h04, 10);
      cyc(1, 1, 5'h08, 0);
      n = 0;
      while (!irq[7] && n < 100) begin
         cyc(0, 0, 0, 0);
         n++;
      end
      chk("mti_rise_in_time", n < 100, 1);
      cyc(1, 1, 5'h08, 32'hFFFF_FFFF);
      chk("mti_hold_n1", irq[7], 1);
      cyc(0, 0, 0, 0);
      chk("mti_clear_n2", irq[7], 0);

      // carry from LO into HI, and a LO write on a tick cycle
      cyc(1, 1, 5'h14, 0);
      cyc(1, 1, 5'h10, 0);
      cyc(1, 1, 5'h0C, 32'hFFFF_FFFF);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 5'h10, 0);
      chk("carry_hi", rdata, 1);
      cyc(1, 1, 5'h0C, 32'hABCD);
      cyc(1, 0, 5'h0C, 0);
      chk("tick_write_lo", rdata, 32'hABCD);
      cyc(1, 0, 5'h10, 0);
      chk("tick_write_hi_kept", rdata, 1);

      // MSIP pulse
      cyc(1, 1, 5'h00, 1);
      chk("msip_set", irq[3], 1);
      cyc(1, 1, 5'h00, 0);
      chk("msip_clear", irq[3], 0);

`ifdef CV32E40S_IRQ_GEN_FIRQ_EN
      firq = 0;
      repeat (3) cyc(0, 0, 0, 0);
      firq[5] = 1'b1;
      cyc(0, 0, 0, 0);
      chk("firq_lat1", irq[21], 0);
      cyc(0, 0, 0, 0);
      chk("firq_lat2", irq[21], 0);
      cyc(0, 0, 0, 0);
      chk("firq_lat3", irq[21], 1);
      firq[5] = 1'b0;
      cyc(1, 1, 5'h18, 32'h20);
      chk("firq_w1c", irq[21], 0);
      firq[5] = 1'b1;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("firq_pre_set", irq[21], 0);
      cyc(1, 1, 5'h18, 32'h20);
      chk("firq_set_wins", irq[21], 1);
      firq = 0;
`endif

      // random traffic with a reset in the middle
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) begin
            cyc(1, 0, 5'h04, 0);
            #2;
            rst_n = 1'b0;
            #1;
            chk("midrst_rvalid", rvalid, 0);
            chk("midrst_irq", irq, 0);
            m_reset();
            req = 0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         ri = 3'($urandom_range(0, 7));
         rd = $urandom;
         if (ri == 3'd1 || ri == 3'd3) rd = $urandom_range(0, 60);
         if (ri == 3'd2 || ri == 3'd4) rd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'd0;
         if (ri == 3'd5) rd = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) firq = 16'($urandom);
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {ri, 2'($urandom)}, rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
